// File: rtl/vga_sync_pkg.sv
// Shared VGA 640x480@60 timing constants and decode helper.
// Used by vga_sync, ModuloVGA and benches so they all agree on one set of numbers.
package vga_sync_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_PIX_DIV   = 4;
  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;
  localparam bit DEF_SYNC_POL  = 1'b0;

  localparam int H_TOTAL  = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL  = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
  localparam int HS_START = DEF_H_DISPLAY + DEF_H_FRONT;
  localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
  localparam int VS_START = DEF_V_DISPLAY + DEF_V_FRONT;
  localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic video_on;
  } sync_t;

  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_pix_tick.sv
// Pixel-rate clock enable: one-cycle pulse every PIX_DIV system clocks.
module vga_pix_tick #(
  parameter int PIX_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_pix_en
);

  generate
    if (PIX_DIV <= 1) begin : g_every_clk
      logic w_unused_ok;
      assign w_unused_ok = i_clk ^ i_rst_n;
      assign o_pix_en    = 1'b1;
    end else begin : g_div
      localparam int DIV_W = $clog2(PIX_DIV);
      localparam logic [DIV_W-1:0] L_DIV_LAST = DIV_W'(PIX_DIV - 1);

      logic [DIV_W-1:0] r_div;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
          r_div <= '0;
        else if (r_div == L_DIV_LAST)
          r_div <= '0;
        else
          r_div <= r_div + 1'b1;
      end

      assign o_pix_en = (r_div == L_DIV_LAST);
    end
  endgenerate

endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel/line counters with registered sync and blanking decode.
// Decode is taken from the next counter values so flags and coordinates never skew.
module vga_sync
  import vga_sync_pkg::*;
#(
  parameter int PIX_DIV   = DEF_PIX_DIV,
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK,
  parameter bit SYNC_POL  = DEF_SYNC_POL
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             HS,
  output logic             VS,
  output logic             Video_on,
  output logic [CNT_W-1:0] ADDRH,
  output logic [CNT_W-1:0] ADDRV
);

  localparam logic [CNT_W-1:0] L_H_LAST   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [CNT_W-1:0] L_V_LAST   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [CNT_W-1:0] L_H_DISP   = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] L_V_DISP   = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] L_HS_START = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] L_HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] L_VS_START = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] L_VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic             w_pix_en;
  logic [CNT_W-1:0] r_addrh;
  logic [CNT_W-1:0] r_addrv;
  logic [CNT_W-1:0] w_addrh_next;
  logic [CNT_W-1:0] w_addrv_next;
  sync_t            r_sync;
  sync_t            w_sync_next;

  vga_pix_tick #(
    .PIX_DIV (PIX_DIV)
  ) u_pix_tick (
    .i_clk    (CLK),
    .i_rst_n  (RST),
    .o_pix_en (w_pix_en)
  );

  always_comb begin
    w_addrh_next = r_addrh;
    w_addrv_next = r_addrv;
    if (w_pix_en) begin
      if (r_addrh == L_H_LAST) begin
        w_addrh_next = '0;
        if (r_addrv == L_V_LAST)
          w_addrv_next = '0;
        else
          w_addrv_next = r_addrv + 1'b1;
      end else begin
        w_addrh_next = r_addrh + 1'b1;
      end
    end
  end

  always_comb begin
    w_sync_next.hs       = in_window(w_addrh_next, L_HS_START, L_HS_END) ? SYNC_POL : ~SYNC_POL;
    w_sync_next.vs       = in_window(w_addrv_next, L_VS_START, L_VS_END) ? SYNC_POL : ~SYNC_POL;
    w_sync_next.video_on = (w_addrh_next < L_H_DISP) && (w_addrv_next < L_V_DISP);
  end

  // Flags load only on ticks so the reset state (0,0) keeps Video_on low until the first tick.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_addrh         <= '0;
      r_addrv         <= '0;
      r_sync.hs       <= ~SYNC_POL;
      r_sync.vs       <= ~SYNC_POL;
      r_sync.video_on <= 1'b0;
    end else if (w_pix_en) begin
      r_addrh <= w_addrh_next;
      r_addrv <= w_addrv_next;
      r_sync  <= w_sync_next;
    end
  end

  assign ADDRH    = r_addrh;
  assign ADDRV    = r_addrv;
  assign HS       = r_sync.hs;
  assign VS       = r_sync.vs;
  assign Video_on = r_sync.video_on;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a default 640x480 instance at PIX_DIV=4 and a shrunken-timing
// instance at PIX_DIV=1, each compared every cycle against a tick-count model.
module tb_vga_sync;

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       vid;
  } exp_t;

  logic       CLK = 1'b0;
  logic       rst4, rst1;
  logic       hs4, vs4, vid4, hs1, vs1, vid1;
  logic [9:0] addrh4, addrv4, addrh1, addrv1;

  int  n_checks = 0;
  int  n_pass   = 0;
  int  e4 = 0;
  int  e1 = 0;
  int  pos = 0;
  bit  chk_on = 1'b0;

  always #5 CLK = ~CLK;

  vga_sync dut4 (
    .CLK(CLK), .RST(rst4), .HS(hs4), .VS(vs4), .Video_on(vid4),
    .ADDRH(addrh4), .ADDRV(addrv4)
  );

  vga_sync #(
    .PIX_DIV(1), .H_DISPLAY(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(3),
    .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_POL(1'b0)
  ) dut1 (
    .CLK(CLK), .RST(rst1), .HS(hs1), .VS(vs1), .Video_on(vid1),
    .ADDRH(addrh1), .ADDRV(addrv1)
  );

  // Expected outputs after n pixel ticks since reset release.
  function automatic exp_t model(input int n, input int hd, input int hf, input int hsy,
                                 input int hb, input int vd, input int vf, input int vsy,
                                 input int vb, input bit pol);
    exp_t x;
    int ht, vt, h, v;
    ht = hd + hf + hsy + hb;
    vt = vd + vf + vsy + vb;
    h = n % ht;
    v = (n / ht) % vt;
    x.h   = 10'(h);
    x.v   = 10'(v);
    x.hs  = (h >= hd + hf && h < hd + hf + hsy) ? pol : !pol;
    x.vs  = (v >= vd + vf && v < vd + vf + vsy) ? pol : !pol;
    x.vid = (n != 0) && (h < hd) && (v < vd);
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
  endtask

  task automatic cmp_state(input string nm, input exp_t a, input exp_t x);
    n_checks++;
    if (a == x) n_pass++;
    else $display("FAIL %s: got h=%0d v=%0d hs=%0b vs=%0b vid=%0b, expected h=%0d v=%0d hs=%0b vs=%0b vid=%0b (t=%0t)",
                  nm, a.h, a.v, a.hs, a.vs, a.vid, x.h, x.v, x.hs, x.vs, x.vid, $time);
  endtask

  task automatic advance(input int k);
    repeat (k - pos) @(posedge CLK);
    pos = k;
    #1;
  endtask

  always @(posedge CLK or negedge rst4)
    if (!rst4) e4 <= 0; else e4 <= e4 + 1;

  always @(posedge CLK or negedge rst1)
    if (!rst1) e1 <= 0; else e1 <= e1 + 1;

  always @(negedge CLK) begin : cmp_proc
    exp_t a, x;
    if (chk_on) begin
      a = '{h: addrh4, v: addrv4, hs: hs4, vs: vs4, vid: vid4};
      x = model(e4 / 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      cmp_state("dut4_cycle", a, x);
      a = '{h: addrh1, v: addrv1, hs: hs1, vs: vs1, vid: vid1};
      x = model(e1, 16, 2, 4, 3, 10, 2, 2, 3, 1'b0);
      cmp_state("dut1_cycle", a, x);
    end
  end

  // Every frame of the small instance must hold exactly V_TOTAL HS pulses.
  logic prev_hs1 = 1'b1, prev_vs1 = 1'b1;
  bit   seen_vs1 = 1'b0;
  int   hs_cnt1 = 0;
  always @(negedge CLK) begin
    if (!rst1) begin
      prev_hs1 = 1'b1; prev_vs1 = 1'b1; seen_vs1 = 1'b0; hs_cnt1 = 0;
    end else if (chk_on) begin
      if (prev_hs1 && !hs1) hs_cnt1++;
      if (prev_vs1 && !vs1) begin
        if (seen_vs1) chk("hs_per_vs", hs_cnt1, 17);
        hs_cnt1  = 0;
        seen_vs1 = 1'b1;
      end
      prev_hs1 = hs1;
      prev_vs1 = vs1;
    end
  end

  initial begin
    rst4 = 1'b1; rst1 = 1'b1;
    #1 rst4 = 1'b0; rst1 = 1'b0; chk_on = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    chk("rst_addrh", addrh4, 0);
    chk("rst_addrv", addrv4, 0);
    chk("rst_hs", hs4, 1);
    chk("rst_vs", vs4, 1);
    chk("rst_vid", vid4, 0);
    chk("rst_vid_small", vid1, 0);

    @(negedge CLK); rst4 = 1'b1; rst1 = 1'b1; pos = 0;
    advance(3);    chk("hold_before_tick", addrh4, 0);
    advance(4);    chk("first_tick_h", addrh4, 1);
                   chk("small_every_clk", addrh1, 4);
    advance(300);  chk("small_v12_h", addrh1, 0);
                   chk("small_v12_v", addrv1, 12);
                   chk("small_vs_on", vs1, 0);
    advance(424);  chk("small_last_h", addrh1, 24);
                   chk("small_last_v", addrv1, 16);
                   chk("small_last_vid", vid1, 0);
    advance(425);  chk("small_wrap_h", addrh1, 0);
                   chk("small_wrap_v", addrv1, 0);
                   chk("small_wrap_vid", vid1, 1);
    advance(2560); chk("h640", addrh4, 640);
                   chk("h640_vid", vid4, 0);
    advance(2620); chk("h655", addrh4, 655);
                   chk("h655_hs", hs4, 1);
    advance(2624); chk("h656_hs", hs4, 0);
    advance(3004); chk("h751", addrh4, 751);
                   chk("h751_hs", hs4, 0);
    advance(3008); chk("h752_hs", hs4, 1);
    advance(3200); chk("line1_h", addrh4, 0);
                   chk("line1_v", addrv4, 1);
                   chk("line1_vid", vid4, 1);
    advance(4400); chk("mid_h", addrh4, 300);
                   chk("mid_v", addrv4, 1);

    rst4 = 1'b0; rst1 = 1'b0;
    #1;
    chk("async_clr_h", addrh4, 0);
    chk("async_clr_v", addrv4, 0);
    chk("async_clr_hs", hs4, 1);
    chk("async_clr_vid", vid4, 0);
    chk("async_clr_small_h", addrh1, 0);
    repeat (3) @(posedge CLK);
    @(negedge CLK); rst4 = 1'b1; rst1 = 1'b1; pos = 0;
    advance(3);    chk("restart_hold", addrh4, 0);
    advance(4);    chk("restart_h", addrh4, 1);
                   chk("restart_v", addrv4, 0);
                   chk("restart_vid", vid4, 1);
    advance(1000);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
